class_fifo: RTL and testbench



---
 rtl/class_pkg.sv | 22 ++
 rtl/class_fifo_mem.sv | 34 +++
 rtl/class_fifo.sv | 104 ++++++++++
 tb/tb_class_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/class_pkg.sv
// Shared definitions for the class demux, per-class FIFOs and destination router.
// Word layout: {class, dest, payload[7:0]}.
package class_pkg;

  localparam int WORD_WIDTH    = 10;
  localparam int CLASS_BIT     = 9;
  localparam int DEST_BIT      = 8;
  localparam int DATA_MSB      = 7;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 2;

  function automatic logic word_class(input logic [WORD_WIDTH-1:0] w);
    return w[CLASS_BIT];
  endfunction

  function automatic logic word_dest(input logic [WORD_WIDTH-1:0] w);
    return w[DEST_BIT];
  endfunction

endpackage

// File: rtl/class_fifo_mem.sv
// Storage array for class_fifo: synchronous write, registered read port.
// The read register is read-before-write, so a same-address push and pop returns the old word.
module class_fifo_mem #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/class_fifo.sv
// Per-class output FIFO with count-based full/empty/almost flags.
// Define CLASS_FIFO_ERR_EN to add sticky err_overflow / err_underflow outputs.
module class_fifo
  import class_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEF_AF_THRESH,
  parameter int AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count
`ifdef CLASS_FIFO_ERR_EN
  ,
  output logic                       err_overflow,
  output logic                       err_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          valid_reg;
  logic          pop_acc, push_acc;

  // Reset-cycle requests are ignored, so acceptance is gated here as well.
  assign pop_acc  = pop && !empty && !reset;
  assign push_acc = push && (!full || pop_acc) && !reset;

  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      valid_reg <= pop_acc;
    end
  end

  class_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr_reg),
    .rd_data (data_out)
  );

  assign valid_out    = valid_reg;
  assign count        = count_reg;
  assign full         = (count_reg == CW'(DEPTH));
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= CW'(AF_THRESH));
  assign almost_empty = (count_reg <= CW'(AE_THRESH));

`ifdef CLASS_FIFO_ERR_EN
  logic ovf_reg, unf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (push && full && !pop) ovf_reg <= 1'b1;
      if (pop && empty)         unf_reg <= 1'b1;
    end
  end

  assign err_overflow  = ovf_reg;
  assign err_underflow = unf_reg;
`endif

endmodule

// File: tb/tb_class_fifo.sv
// Self-checking bench for class_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_class_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] count;
`ifdef CLASS_FIFO_ERR_EN
  logic       err_overflow, err_underflow;
`endif

  class_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef CLASS_FIFO_ERR_EN
    ,
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [9:0] q[$];
  logic [9:0] m_dout  = '0;
  logic       m_valid = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_unf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic p, input logic [9:0] d, input logic o);
    bit was_full, was_empty, pa, wa;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    pa = o && !was_empty;
    wa = p && (!was_full || pa);
    if (r) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (p && was_full && !o) m_ovf = 1'b1;
      if (o && was_empty)      m_unf = 1'b1;
      m_valid = pa;
      if (pa) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_dout));
`ifdef CLASS_FIFO_ERR_EN
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_unf));
`endif
  endtask

  // One clock cycle: drive, let the edge happen, advance model, compare at negedge.
  task automatic cyc(input logic p, input logic [9:0] d, input logic o, input logic r = 1'b0);
    push = p; data_in = d; pop = o; reset = r;
    @(posedge clk);
    model_step(r, p, d, o);
    @(negedge clk);
    compare_all();
    $display("cyc t=%0t rst=%0b push=%0b din=%03h pop=%0b -> cnt=%0d vout=%0b dout=%03h",
             $time, r, p, d, o, count, valid_out, data_out);
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(1, 10'h3FF, 1, 1);
    cyc(0, 0, 0);
    // reset/idle literals
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_vout", 32'(valid_out), 0);
    chk("rst_dout", 32'(data_out), 0);

    // three pushes then three pops
    cyc(1, 10'h155, 0);
    cyc(1, 10'h2AA, 0);
    cyc(1, 10'h0FF, 0);
    chk("p3_count", 32'(count), 3);
    cyc(0, 0, 1); chk("p3_d0", 32'(data_out), 32'h155); chk("p3_v0", 32'(valid_out), 1);
    cyc(0, 0, 1); chk("p3_d1", 32'(data_out), 32'h2AA);
    cyc(0, 0, 1); chk("p3_d2", 32'(data_out), 32'h0FF);
    chk("p3_cnt_end", 32'(count), 0);

    // fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      cyc(1, 10'(32'h100 + i), 0);
      if (i == 4) chk("fill_af5", 32'(almost_full), 0);
      if (i == 5) chk("fill_af6", 32'(almost_full), 1);
      if (i == 6) chk("fill_full7", 32'(full), 0);
      if (i == 7) chk("fill_full8", 32'(full), 1);
    end
    cyc(1, 10'h3FF, 0);
    chk("ovf_count", 32'(count), 8);
`ifdef CLASS_FIFO_ERR_EN
    chk("ovf_err", 32'(err_overflow), 1);
`endif
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("drain_order", 32'(data_out), 32'h100 + i);
    end

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) cyc(1, 10'(32'h080 + i), 0);
    cyc(1, 10'h3C3, 1);
    chk("fpp_count", 32'(count), 8);
    chk("fpp_dout", 32'(data_out), 32'h080);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("fpp_last", 32'(data_out), 32'h3C3);

    // pop on empty
    cyc(0, 0, 1);
    chk("uf_vout", 32'(valid_out), 0);
    chk("uf_dout", 32'(data_out), 32'h3C3);
    chk("uf_count", 32'(count), 0);
`ifdef CLASS_FIFO_ERR_EN
    chk("uf_err", 32'(err_underflow), 1);
`endif
    cyc(1, 10'h0AA, 1);
    chk("epp_count", 32'(count), 1);
    chk("epp_vout", 32'(valid_out), 0);
    cyc(0, 0, 1);
    chk("epp_dout", 32'(data_out), 32'h0AA);

    // wrap-around with count held at 3
    for (int i = 0; i < 3; i++) cyc(1, 10'(32'h200 + i), 0);
    for (int k = 0; k < 20; k++) begin
      cyc(1, 10'(32'h203 + k), 1);
      chk("wrap_dout", 32'(data_out), 32'h200 + k);
      chk("wrap_count", 32'(count), 3);
    end
    cyc(1, 10'h111, 0);
    cyc(1, 10'h112, 0);
    chk("pre_rst_count", 32'(count), 5);
    cyc(1, 10'h113, 1, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    cyc(0, 0, 1);
    chk("post_rst_vout", 32'(valid_out), 0);

    // randomized traffic, push-heavy then pop-heavy
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i < 200) ? 70 : 30;
      cyc(($urandom_range(0, 99) < bias), 10'($urandom_range(0, 1023)),
          ($urandom_range(0, 99) < (100 - bias)), ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
